// File: rtl/branch_resolve_queue_pkg.sv
// Shared configuration for the branch resolve queue: payload types and PC width.
// Optional feature macro used by the top: BRQ_BYPASS_EN (empty-queue bypass).
package branch_resolve_queue_pkg;

  localparam int unsigned VLEN = 32;

  // Resolved branch from one issue slot.
  typedef struct packed {
    logic            valid;
    logic            is_cond;
    logic            taken;
    logic [VLEN-1:0] pc;
  } branch_resolve_t;

  // Training update toward the branch history table.
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  // A slot is worth recording only for a valid conditional branch.
  function automatic logic is_qualified(input branch_resolve_t r);
    return r.valid & r.is_cond;
  endfunction

endpackage

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: collects conditional-branch outcomes from two issue
// slots into a small FIFO and drains one per cycle toward the BHT.
// Optional build macro: BRQ_BYPASS_EN -- when the queue is empty, the first
// qualified entry goes straight to bht_update_o instead of being enqueued.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  branch_resolve_t [1:0] resolve_i,
  output logic                  ready_o,
  output logic                  overflow_o,
  output bht_update_t           bht_update_o
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Elaboration guard on the queue geometry.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("branch_resolve_queue: DEPTH must be a power of two and >= 2");
  end

  logic [VLEN-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [1:0]       qual;
  logic [1:0]       n_qual;
  logic             accept;
  logic             pop;
  logic             drop;
  logic             byp_fire;
  logic [1:0]       push_n;
  logic [1:0]       wr_en;
  logic [VLEN-1:0]  wr_pc0;
  logic [VLEN-1:0]  wr_pc1;
  logic             wr_tk0;
  logic             wr_tk1;
  logic [VLEN-1:0]  first_pc;
  logic             first_tk;
  logic [CW-1:0]    count_nxt;

  // Space for a full two-slot push, judged on the registered count only.
  assign ready_o = (CW'(DEPTH) - count) >= CW'(2);

  // Qualify, compact slot 1 behind slot 0, and decide push/pop/drop.
  always_comb begin
    qual      = {is_qualified(resolve_i[1]), is_qualified(resolve_i[0])};
    n_qual    = {1'b0, qual[0]} + {1'b0, qual[1]};
    accept    = ready_o & ~flush_i;
    pop       = (count != '0) & ~flush_i;
    drop      = ~flush_i & ~ready_o & (|qual);
    first_pc  = qual[0] ? resolve_i[0].pc    : resolve_i[1].pc;
    first_tk  = qual[0] ? resolve_i[0].taken : resolve_i[1].taken;
    byp_fire  = 1'b0;
    push_n    = 2'd0;
    wr_en     = 2'b00;
    wr_pc0    = first_pc;
    wr_tk0    = first_tk;
    wr_pc1    = resolve_i[1].pc;
    wr_tk1    = resolve_i[1].taken;
    if (accept) begin
`ifdef BRQ_BYPASS_EN
      if (count == '0 && n_qual != 2'd0) begin
        byp_fire = 1'b1;
        wr_pc0   = resolve_i[1].pc;
        wr_tk0   = resolve_i[1].taken;
        wr_en[0] = (n_qual == 2'd2);
        push_n   = n_qual - 2'd1;
      end else begin
        wr_en  = {n_qual == 2'd2, n_qual != 2'd0};
        push_n = n_qual;
      end
`else
      wr_en  = {n_qual == 2'd2, n_qual != 2'd0};
      push_n = n_qual;
`endif
    end
    count_nxt = count + CW'(push_n) - CW'(pop);
  end

  // Pointers, occupancy, overflow pulse and the registered BHT update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_o   <= 1'b0;
      bht_update_o <= '0;
    end else if (flush_i) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      overflow_o         <= 1'b0;
      bht_update_o.valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push_n);
      rd_ptr     <= rd_ptr + PW'(pop);
      count      <= count_nxt;
      overflow_o <= drop;
      if (byp_fire) begin
        bht_update_o <= '{valid: 1'b1, pc: first_pc, taken: first_tk};
      end else if (pop) begin
        bht_update_o <= '{valid: 1'b1, pc: pc_mem[rd_ptr], taken: taken_mem[rd_ptr]};
      end else begin
        bht_update_o.valid <= 1'b0;
      end
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en[0]) begin
      pc_mem[wr_ptr]    <= wr_pc0;
      taken_mem[wr_ptr] <= wr_tk0;
    end
    if (wr_en[1]) begin
      pc_mem[wr_ptr + PW'(1)]    <= wr_pc1;
      taken_mem[wr_ptr + PW'(1)] <= wr_tk1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios followed by
// random traffic, all compared against a FIFO-queue reference model.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic            taken;
    logic [VLEN-1:0] pc;
  } ent_t;

  logic                  clk_i;
  logic                  rst_i;
  logic                  flush_i;
  branch_resolve_t [1:0] resolve_i;
  logic                  ready_o;
  logic                  overflow_o;
  bht_update_t           bht_update_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ent_t        mq[$];
  bht_update_t exp_bht;
  logic        exp_ovf;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .resolve_i   (resolve_i),
    .ready_o     (ready_o),
    .overflow_o  (overflow_o),
    .bht_update_o(bht_update_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic branch_resolve_t mk(input logic v, input logic c, input logic t,
                                         input logic [VLEN-1:0] pc);
    branch_resolve_t r;
    r.valid = v; r.is_cond = c; r.taken = t; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the spec rules, then compare after the edge.
  task automatic step();
    int   sz;
    bit   rdy;
    ent_t ql[$];
    ent_t e;
    sz  = mq.size();
    rdy = (int'(DEPTH) - sz) >= 2;
    for (int s = 0; s < 2; s++)
      if (resolve_i[s].valid && resolve_i[s].is_cond)
        ql.push_back('{taken: resolve_i[s].taken, pc: resolve_i[s].pc});
    if (flush_i) begin
      mq.delete();
      exp_bht.valid = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      exp_ovf = 1'b0;
      if (sz > 0) begin
        e = mq.pop_front();
        exp_bht = '{valid: 1'b1, pc: e.pc, taken: e.taken};
      end else begin
        exp_bht.valid = 1'b0;
      end
      if (rdy) begin
`ifdef BRQ_BYPASS_EN
        if (sz == 0 && ql.size() > 0) begin
          e = ql.pop_front();
          exp_bht = '{valid: 1'b1, pc: e.pc, taken: e.taken};
        end
`endif
        foreach (ql[i]) mq.push_back(ql[i]);
      end else if (ql.size() > 0) begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    chk("ready", 64'(ready_o), 64'((int'(DEPTH) - mq.size()) >= 2));
    chk("overflow", 64'(overflow_o), 64'(exp_ovf));
    chk("bht_update", 64'(bht_update_o), 64'(exp_bht));
  endtask

  task automatic idle();
    resolve_i = '0;
    flush_i   = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    exp_bht = '0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_bht", 64'(bht_update_o), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_ovf", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;

    // Single conditional branch latency and one-cycle output.
    resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h8000_0010);
    step();
    idle();
`ifdef BRQ_BYPASS_EN
    chk("lat_first", 64'(bht_update_o), 64'({1'b1, 32'h8000_0010, 1'b1}));
    step();
    chk("lat_after", 64'(bht_update_o.valid), 64'd0);
`else
    chk("lat_first", 64'(bht_update_o.valid), 64'd0);
    step();
    chk("lat_second", 64'(bht_update_o), 64'({1'b1, 32'h8000_0010, 1'b1}));
    step();
    chk("lat_after", 64'(bht_update_o.valid), 64'd0);
    chk("lat_hold_pc", 64'(bht_update_o.pc), 64'(32'h8000_0010));
`endif

    // Two slots for two cycles: fill, back-pressure, FIFO order.
    for (int c = 0; c < 2; c++) begin
      resolve_i[0] = mk(1'b1, 1'b1, 1'b0, 32'h100);
      resolve_i[1] = mk(1'b1, 1'b1, 1'b1, 32'h104);
      step();
    end
    idle();
    repeat (5) step();

    // Fill to 3 then offer one more: dropped with a single overflow pulse.
    idle();
    repeat (3) step();
    for (int c = 0; c < 2; c++) begin
      resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h300 + 32'(c * 8));
      resolve_i[1] = mk(1'b1, 1'b1, 1'b0, 32'h304 + 32'(c * 8));
      step();
    end
    resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h3F0);
    resolve_i[1] = '0;
    step();
    chk("ovf_pulse", 64'(overflow_o), 64'd1);
    idle();
    step();
    chk("ovf_single", 64'(overflow_o), 64'd0);
    repeat (4) step();

    // Non-conditional slot 0 with qualified slot 1: compacted, only 0x200 out.
    resolve_i[0] = mk(1'b1, 1'b0, 1'b1, 32'h1FC);
    resolve_i[1] = mk(1'b1, 1'b1, 1'b1, 32'h200);
    step();
    idle();
    repeat (3) step();

    // Flush with 3 queued and a qualified input.
    resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h400);
    resolve_i[1] = mk(1'b1, 1'b1, 1'b0, 32'h404);
    step();
    resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h408);
    resolve_i[1] = mk(1'b1, 1'b1, 1'b0, 32'h40C);
    step();
    resolve_i[0] = mk(1'b1, 1'b1, 1'b1, 32'h410);
    resolve_i[1] = '0;
    flush_i = 1'b1;
    step();
    chk("flush_valid", 64'(bht_update_o.valid), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_ovf", 64'(overflow_o), 64'd0);
    idle();
    repeat (2) step();

    // Ten push/pop cycles wrapping the pointers, then a mid-stream reset.
    for (int c = 0; c < 10; c++) begin
      resolve_i[0] = mk(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom());
      resolve_i[1] = mk(1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom());
      step();
    end
    idle();
    #2;
    rst_i = 1'b1;
    #1;
    mq.delete();
    exp_bht = '0;
    exp_ovf = 1'b0;
    chk("midrst_bht", 64'(bht_update_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (4) step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      resolve_i[0] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), $urandom());
      resolve_i[1] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), $urandom());
      flush_i = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
